// File: rtl/ipg_tx_frame_buffer.sv
// Store-and-forward TX frame buffer between a frame source and the MAC tx_axis port.
// Optional: define IPG_TX_DROP_BAD_FRAME_EN to discard frames whose tlast carries tuser[0]=1.
module ipg_tx_frame_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int DEPTH      = 512
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst_n,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  input  logic [USER_WIDTH-1:0]   s_axis_tuser,
  output logic                    s_axis_tready,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  output logic [USER_WIDTH-1:0]   m_axis_tuser,
  input  logic                    m_axis_tready,
  output logic                    status_good_frame,
  output logic                    status_bad_frame,
  output logic                    status_overflow,
  output logic [$clog2(DEPTH):0]  fill_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = DATA_WIDTH + KEEP_WIDTH + 1 + USER_WIDTH;
  localparam logic [PW-1:0] ONE     = PW'(1);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);

  typedef enum logic {ST_IDLE, ST_DROP} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d, fill_q;
  logic          rdy_q, out_valid_q, out_valid_d;
  logic          good_q, good_d, bad_q, bad_d, ovf_q, ovf_d;
  logic          accept, full, bad_tlast, wr_en, pop, load;
  logic [WW-1:0] mem [DEPTH];
  logic [WW-1:0] out_q;

  assign accept = s_axis_tvalid & rdy_q;
  assign full   = (wr_ptr_q - rd_ptr_q) == DEPTH_P;

`ifdef IPG_TX_DROP_BAD_FRAME_EN
  assign bad_tlast = s_axis_tlast & s_axis_tuser[0];
`else
  assign bad_tlast = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_en       = 1'b0;
    good_d      = 1'b0;
    bad_d       = 1'b0;
    ovf_d       = 1'b0;
    if (accept) begin
      case (state_q)
        ST_IDLE: begin
          if (full) begin
            // Rewind to the last commit; an overflowing tlast word ends the drop at once.
            wr_ptr_d = wr_commit_q;
            if (s_axis_tlast) ovf_d = 1'b1;
            else              state_d = ST_DROP;
          end else begin
            wr_en    = 1'b1;
            wr_ptr_d = wr_ptr_q + ONE;
            if (s_axis_tlast) begin
              if (bad_tlast) begin
                wr_ptr_d = wr_commit_q;
                bad_d    = 1'b1;
              end else begin
                wr_commit_d = wr_ptr_q + ONE;
                good_d      = 1'b1;
              end
            end
          end
        end
        ST_DROP: begin
          if (s_axis_tlast) begin
            state_d = ST_IDLE;
            ovf_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // rd_ptr addresses the word held in the output register, so fill_level counts it.
  always_comb begin
    pop         = out_valid_q & m_axis_tready;
    rd_ptr_d    = pop ? rd_ptr_q + ONE : rd_ptr_q;
    load        = (~out_valid_q | pop) & (wr_commit_q != rd_ptr_d);
    out_valid_d = (out_valid_q & ~pop) | load;
  end

  always_ff @(posedge tx_clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      wr_commit_q <= '0;
      rd_ptr_q    <= '0;
      fill_q      <= '0;
      rdy_q       <= 1'b0;
      out_valid_q <= 1'b0;
      good_q      <= 1'b0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      fill_q      <= wr_commit_q - rd_ptr_q;
      rdy_q       <= 1'b1;
      out_valid_q <= out_valid_d;
      good_q      <= good_d;
      bad_q       <= bad_d;
      ovf_q       <= ovf_d;
    end
  end

  always_ff @(posedge tx_clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tkeep, s_axis_tdata};
    if (load)  out_q <= mem[rd_ptr_d[AW-1:0]];
  end

  assign s_axis_tready     = rdy_q;
  assign m_axis_tvalid     = out_valid_q;
  assign m_axis_tdata      = out_q[DATA_WIDTH-1:0];
  assign m_axis_tkeep      = out_q[DATA_WIDTH +: KEEP_WIDTH];
  assign m_axis_tlast      = out_q[DATA_WIDTH+KEEP_WIDTH];
  assign m_axis_tuser      = out_q[WW-1 -: USER_WIDTH];
  assign status_good_frame = good_q;
  assign status_bad_frame  = bad_q;
  assign status_overflow   = ovf_q;
  assign fill_level        = fill_q;

endmodule

// File: tb/tb_ipg_tx_frame_buffer.sv
// Directed bench for ipg_tx_frame_buffer (DEPTH=16): frame table plus latency, toggle and reset sequences.
module tb_ipg_tx_frame_buffer;

  logic        tx_clk = 1'b0;
  logic        tx_rst_n = 1'b0;
  logic [63:0] s_tdata = '0;
  logic [7:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0;
  logic [0:0]  s_tuser = '0;
  logic        s_tready;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic        m_tvalid, m_tlast;
  logic [0:0]  m_tuser;
  logic        m_tready = 1'b1;
  logic        st_good, st_bad, st_ovf;
  logic [4:0]  fill;

  ipg_tx_frame_buffer #(.DATA_WIDTH(64), .USER_WIDTH(1), .DEPTH(16)) dut (
    .tx_clk(tx_clk), .tx_rst_n(tx_rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser), .m_axis_tready(m_tready),
    .status_good_frame(st_good), .status_bad_frame(st_bad), .status_overflow(st_ovf),
    .fill_level(fill)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic        u;
  } word_t;

  typedef struct {
    int          len;
    logic [7:0]  last_keep;
    bit          bad;
    bit          hold;
    int          exp_words;
    int          exp_good;
    int          exp_bad;
    int          exp_ovf;
  } vec_t;

  word_t exp_q[$];
  int    checks = 0, errors = 0;
  int    good_cnt = 0, bad_cnt = 0, ovf_cnt = 0;
  bit    stall_q = 1'b0;
  word_t stall_w;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Words are sampled on the falling edge; a valid&&ready seen here transfers on the next rising edge.
  always @(negedge tx_clk) begin
    word_t cur;
    word_t e;
    cur = {m_tdata, m_tkeep, m_tlast, m_tuser};
    if (!tx_rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q) begin
        check("stall_valid", 128'(m_tvalid), 128'(1));
        check("stall_data", 128'(cur), 128'(stall_w));
      end
      if (m_tvalid && m_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word actual=%0h required=none", cur);
        end else begin
          e = exp_q.pop_front();
          check("out_word", 128'(cur), 128'(e));
        end
      end
      stall_q = m_tvalid && !m_tready;
      stall_w = cur;
    end
    if (st_good) good_cnt++;
    if (st_bad)  bad_cnt++;
    if (st_ovf)  ovf_cnt++;
  end

  task automatic send_frame(input int len, input int tag, input logic [7:0] last_keep,
                            input bit bad, input bit push);
    for (int i = 0; i < len; i++) begin
      word_t w;
      w.d = {32'(tag), 32'(i)};
      w.l = (i == len - 1);
      w.k = w.l ? last_keep : 8'hFF;
      w.u = w.l ? bad : 1'b0;
      s_tdata  = w.d;
      s_tkeep  = w.k;
      s_tlast  = w.l;
      s_tuser  = w.u;
      s_tvalid = 1'b1;
      if (push) exp_q.push_back(w);
      @(posedge tx_clk); #1;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = '0;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 300; c++) begin
      @(negedge tx_clk);
      if (exp_q.size() == 0 && !m_tvalid) break;
    end
    check({name, "_drained"}, 128'(exp_q.size()), 128'(0));
    repeat (2) @(posedge tx_clk);
    #1;
    check({name, "_fill0"}, 128'(fill), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int g0, b0, o0;
    vecs[0] = '{8,  8'hFF, 1'b0, 1'b0, 8,  1, 0, 0};
    vecs[1] = '{1,  8'h01, 1'b0, 1'b0, 1,  1, 0, 0};
    vecs[2] = '{16, 8'h0F, 1'b0, 1'b1, 16, 1, 0, 0};
    vecs[3] = '{17, 8'hFF, 1'b0, 1'b0, 0,  0, 0, 1};
    vecs[4] = '{4,  8'h3F, 1'b0, 1'b0, 4,  1, 0, 0};
    vecs[5] = '{20, 8'hFF, 1'b0, 1'b0, 0,  0, 0, 1};
`ifdef IPG_TX_DROP_BAD_FRAME_EN
    vecs[6] = '{3,  8'h07, 1'b1, 1'b0, 0,  0, 1, 0};
`else
    vecs[6] = '{3,  8'h07, 1'b1, 1'b0, 3,  1, 0, 0};
`endif
    vecs[7] = '{5,  8'h80, 1'b0, 1'b1, 5,  1, 0, 0};

    // Reset state
    @(negedge tx_clk);
    check("rst_m_tvalid", 128'(m_tvalid), 128'(0));
    check("rst_s_tready", 128'(s_tready), 128'(0));
    check("rst_fill", 128'(fill), 128'(0));
    check("rst_status", 128'({st_good, st_bad, st_ovf}), 128'(0));
    @(posedge tx_clk); #1;
    tx_rst_n = 1'b1;
    repeat (2) @(posedge tx_clk);
    #1;
    check("s_tready_high", 128'(s_tready), 128'(1));

    // First-word latency and contiguous 8-word burst
    send_frame(8, 32'hA0, 8'hFF, 1'b0, 1'b1);
    check("lat_valid_edge1", 128'(m_tvalid), 128'(0));
    check("lat_good_pulse", 128'(st_good), 128'(1));
    @(posedge tx_clk); #1;
    check("lat_valid_edge2", 128'(m_tvalid), 128'(1));
    check("lat_first_data", 128'(m_tdata), 128'({32'hA0, 32'd0}));
    check("lat_good_single", 128'(st_good), 128'(0));
    for (int i = 0; i < 8; i++) begin
      @(negedge tx_clk);
      check("burst_valid", 128'(m_tvalid), 128'(1));
      check("burst_last", 128'(m_tlast), 128'(i == 7));
    end
    @(negedge tx_clk);
    check("burst_end", 128'(m_tvalid), 128'(0));
    drain("lat");

    // Frame table
    foreach (vecs[v]) begin
      g0 = good_cnt; b0 = bad_cnt; o0 = ovf_cnt;
      m_tready = !vecs[v].hold;
      send_frame(vecs[v].len, 32'h100 + v, vecs[v].last_keep, vecs[v].bad, vecs[v].exp_words > 0);
      if (vecs[v].hold) begin
        repeat (3) @(posedge tx_clk);
        #1;
        check($sformatf("v%0d_fill_held", v), 128'(fill), 128'(vecs[v].len));
        m_tready = 1'b1;
      end
      drain($sformatf("v%0d", v));
      check($sformatf("v%0d_good", v), 128'(good_cnt - g0), 128'(vecs[v].exp_good));
      check($sformatf("v%0d_bad", v),  128'(bad_cnt - b0),  128'(vecs[v].exp_bad));
      check($sformatf("v%0d_ovf", v),  128'(ovf_cnt - o0),  128'(vecs[v].exp_ovf));
    end

    // Three 5-word frames with tready toggling every cycle
    g0 = good_cnt;
    m_tready = 1'b1;
    fork
      begin
        send_frame(5, 32'h200, 8'h1F, 1'b0, 1'b1);
        send_frame(5, 32'h201, 8'h3F, 1'b0, 1'b1);
        send_frame(5, 32'h202, 8'h7F, 1'b0, 1'b1);
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(posedge tx_clk); #1;
          m_tready = ~m_tready;
        end
      end
    join
    m_tready = 1'b1;
    drain("toggle");
    check("toggle_good", 128'(good_cnt - g0), 128'(3));

    // Reset mid-frame with a committed frame held in the buffer
    m_tready = 1'b0;
    send_frame(4, 32'h300, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      s_tdata = {32'h301, 32'(i)}; s_tkeep = 8'hFF; s_tlast = 1'b0; s_tvalid = 1'b1;
      @(posedge tx_clk); #1;
    end
    s_tvalid = 1'b0;
    check("pre_rst_valid", 128'(m_tvalid), 128'(1));
    tx_rst_n = 1'b0;
    #1;
    check("midrst_valid", 128'(m_tvalid), 128'(0));
    check("midrst_fill", 128'(fill), 128'(0));
    check("midrst_tready", 128'(s_tready), 128'(0));
    @(posedge tx_clk); #1;
    tx_rst_n = 1'b1;
    m_tready = 1'b1;
    repeat (2) @(posedge tx_clk);
    #1;
    check("postrst_valid", 128'(m_tvalid), 128'(0));
    send_frame(6, 32'h400, 8'h0F, 1'b0, 1'b1);
    drain("postrst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipg_tx_frame_buffer.md
IPG_TX_FRAME_BUFFER -- requirements
Module: ipg_tx_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, tdata width in bits.
REQ-002 SHALL have parameter KEEP_WIDTH, default DATA_WIDTH/8, tkeep width.
REQ-003 SHALL have parameter USER_WIDTH, default 1, tuser width; bit 0 is the bad-frame flag.
REQ-004 SHALL have parameter DEPTH, default 512, buffer depth in words; power of two, at least 16.
REQ-005 SHALL have port tx_clk, input, 1, the single clock; it is the MAC tx clock.
REQ-006 SHALL have port tx_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports s_axis_tdata/tkeep/tvalid/tlast/tuser, inputs, DATA_WIDTH/KEEP_WIDTH/1/1/USER_WIDTH, the upstream frame source.
REQ-008 SHALL have port s_axis_tready, output, 1, input accept.
REQ-009 SHALL have ports m_axis_tdata/tkeep/tvalid/tlast/tuser, outputs, same widths, driving the MAC tx_axis inputs.
REQ-010 SHALL have port m_axis_tready, input, 1, driven by MAC tx_axis_tready.
REQ-011 SHALL have ports status_good_frame, status_bad_frame, status_overflow, outputs, 1 each, single-cycle event pulses.
REQ-012 SHALL have port fill_level, output, clog2(DEPTH)+1, number of committed words buffered.

Function
REQ-013 SHALL operate store-and-forward: no word of a frame appears on m_axis until that frame's tlast has been accepted and committed, so the MAC never sees a mid-frame gap (tx_error_underflow impossible).
REQ-014 SHALL hold s_axis_tready high whenever out of reset; overload is handled by dropping, never by back-pressure.
REQ-015 SHALL keep write pointer wr_ptr, committed pointer wr_commit and read pointer rd_ptr, each clog2(DEPTH)+1 bits, wrapping modulo 2*DEPTH; full when wr_ptr-rd_ptr==DEPTH.
REQ-016 SHALL write each accepted word at wr_ptr and advance it, unless in DROP state.
REQ-017 SHALL, when a word is accepted while full, enter DROP: wr_ptr restored to wr_commit and all remaining words of the frame discarded through tlast.
REQ-018 SHALL, on tlast accepted in DROP, return to IDLE and pulse status_overflow the following cycle.
REQ-019 SHALL, on tlast accepted in normal state, set wr_commit to the post-write wr_ptr and pulse status_good_frame the following cycle (subject to REQ-030).
REQ-020 SHALL accept a frame of exactly DEPTH words (full reached only by the tlast word) and drop a DEPTH+1-word frame.
REQ-021 SHALL present the first word of a committed frame with m_axis_tvalid high on the second tx_clk edge after its tlast was accepted, provided the output was empty.
REQ-022 SHALL advance rd_ptr and the output register when m_axis_tvalid && m_axis_tready; the output holds stable while tready is low.
REQ-023 SHALL stream committed data back-to-back at one word per cycle while m_axis_tready is high, frames concatenated with no idle cycle.
REQ-024 SHALL handle commit and read in the same cycle, and simultaneous write and read at full, with no word lost or duplicated.
REQ-025 SHALL compute fill_level = wr_commit - rd_ptr, registered, one cycle after the event.
REQ-026 SHALL forward tkeep, tlast and tuser unchanged alongside tdata.

Reset
REQ-027 SHALL, while tx_rst_n is low, force all pointers to 0, the state to IDLE, m_axis_tvalid, s_axis_tready, all status pulses and fill_level to 0.
REQ-028 SHALL discard any partial or committed frame on reset mid-operation; the first frame after reset starts clean.
REQ-029 SHALL not reset buffer RAM contents.

Configuration
REQ-030 SHALL honour macro IPG_TX_DROP_BAD_FRAME_EN: when defined, a tlast with s_axis_tuser[0]=1 restores wr_ptr to wr_commit, commits nothing and pulses status_bad_frame; when undefined, such frames commit normally with tuser[0] forwarded, status_good_frame pulses and status_bad_frame is tied 0.

Verification
REQ-031 SHALL cover: 8-word frame, m_axis_tready=1 -> m_axis_tvalid at 2nd edge after tlast, 8 contiguous words, last keep 0xFF, status_good_frame 1 pulse.
REQ-032 SHALL cover: DEPTH=16, 17-word frame then 4-word frame -> status_overflow once, only the 4-word frame emitted, fill_level back to 0.
REQ-033 SHALL cover: 16-word frame into empty DEPTH=16 buffer with m_axis_tready=0 -> accepted, fill_level=16; release tready -> all 16 emitted.
REQ-034 SHALL cover: tuser[0]=1 on tlast with macro defined -> nothing emitted, status_bad_frame pulse; macro undefined -> frame emitted with tuser[0]=1 on its last word.
REQ-035 SHALL cover: m_axis_tready toggling 1/0 every cycle over three 5-word frames -> 15 words in order, data stable while stalled, tlast on words 5/10/15.
REQ-036 SHALL cover: tx_rst_n pulsed low mid-frame with data buffered -> m_axis_tvalid 0 immediately, fill_level 0, next frame emitted intact.
